mul_div_unit: RTL and testbench

Iterative integer multiply/divide unit for the MIPS datapath. It sits between the register file read ports and its write-data path. Operands come straight from the register file rd1/rd2. The HI/LO results return to the register file write port through MFHI/MFLO selection in the writeback mux. Control holds the pipeline while busy is high.

---
 rtl/mul_div_unit_if.sv | 16 +
 rtl/mul_div_unit.sv | 139 +++++++++++++
 tb/tb_mul_div_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the datapath and the iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO unit: N-cycle shift-add multiply / restoring divide on
// operand magnitudes, one fix-up cycle for signs, plus MTHI/MTLO writes.
module mul_div_unit #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mag_b_q, mag_b_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           signed_op;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     mul_sum, div_shift, div_diff;
    logic [2*N-1:0] product;
    logic [N-1:0]   quot, rem;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_b_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_b_q   <= mag_b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start && !bus.op[2]) state_d = RUN;
            RUN:     if (cnt_q == CW'(N - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        signed_op = ~bus.op[0];
        mag_a     = (signed_op && bus.a[N-1]) ? -bus.a : bus.a;
        mag_b     = (signed_op && bus.b[N-1]) ? -bus.b : bus.b;

        mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = acc_q[2*N-1:N-1];
        div_diff  = div_shift - {1'b0, mag_b_q};

        product   = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        rem       = rem_neg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    unique case (bus.op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            cnt_d     = '0;
                            acc_d     = {{N{1'b0}}, mag_a};
                            mag_b_d   = mag_b;
                            is_div_d  = bus.op[1];
                            // A zero divisor leaves an all-ones quotient unnegated; remainder restores to a.
                            neg_d     = signed_op && (bus.a[N-1] ^ bus.b[N-1]) && (bus.b != '0);
                            rem_neg_d = signed_op && bus.a[N-1];
                        end
                        3'b100:  hi_d = bus.a;
                        3'b101:  lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_diff[N]) acc_d = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
                    else              acc_d = {div_shift[N-1:0], acc_q[N-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[N-1:1]};
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = product[2*N-1:N];
                    lo_d = product[N-1:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed plan plus random ops against a 64-bit arithmetic model.
module tb_mul_div_unit;

    localparam int N = 32;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    mul_div_unit_if #(.N(N)) bus ();

    mul_div_unit #(.N(N), .CW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] oh, input logic [31:0] ol,
                                  output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sx, sy, r64;
        logic [63:0] ux, uy, u64;
        sx = 64'(signed'(x));
        sy = 64'(signed'(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        h  = oh;
        l  = ol;
        case (o)
            3'b000: begin r64 = sx * sy; h = r64[63:32]; l = r64[31:0]; end
            3'b001: begin u64 = ux * uy; h = u64[63:32]; l = u64[31:0]; end
            3'b010: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin
                    r64 = sx / sy; l = r64[31:0];
                    r64 = sx % sy; h = r64[31:0];
                end
            end
            3'b011: begin
                if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin
                    u64 = ux / uy; l = u64[31:0];
                    u64 = ux % uy; h = u64[31:0];
                end
            end
            3'b100:  h = x;
            3'b101:  l = x;
            default: ;
        endcase
    endfunction

    // Called at posedge+1; issues the op, checks busy window, hold, and the done cycle.
    // inj>0 asserts a random start during busy cycle inj, which must be ignored.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
        logic [31:0] eh, el;
        model(o, x, y, ref_hi, ref_lo, eh, el);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        for (int c = 1; c <= N + 1; c++) begin
            if (c == inj) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom_range(0, 5));
            end else begin
                bus.start = 1'b0;
            end
            chk($sformatf("busy_c%0d", c), {30'b0, bus.busy, bus.done}, 32'd2);
            if (c == N + 1) begin
                chk("hold_hi", bus.hi, ref_hi);
                chk("hold_lo", bus.lo, ref_lo);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("done_pulse", {30'b0, bus.busy, bus.done}, 32'd1);
        chk($sformatf("hi_op%0d_%h_%h", o, x, y), bus.hi, eh);
        chk($sformatf("lo_op%0d_%h_%h", o, x, y), bus.lo, el);
        ref_hi = eh;
        ref_lo = el;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
        logic [31:0] eh, el;
        model(o, x, 32'h0, ref_hi, ref_lo, eh, el);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ref_hi = eh;
        ref_lo = el;
        chk("mt_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("mt_hi", bus.hi, ref_hi);
        chk("mt_lo", bus.lo, ref_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        tests = 0; fails = 0;
        ref_hi = '0; ref_lo = '0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(3'b000, 32'hFFFF_FFFD, 32'd7, 0);
        chk("mult_neg_hi_const", bus.hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo_const", bus.lo, 32'hFFFF_FFEB);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, bus.done}, 32'd0);

        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_hi_const", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo_const", bus.lo, 32'h0000_0001);

        do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        do_op(3'b011, 32'd100, 32'd7, 0);
        chk("divu_hi_const", bus.hi, 32'd2);
        chk("divu_lo_const", bus.lo, 32'd14);

        do_op(3'b011, 32'h1234_5678, 32'h0, 0);
        chk("divu0_hi_const", bus.hi, 32'h1234_5678);
        chk("divu0_lo_const", bus.lo, 32'hFFFF_FFFF);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("ovf_hi_const", bus.hi, 32'h0);
        chk("ovf_lo_const", bus.lo, 32'h8000_0000);
        do_op(3'b010, 32'hFFFF_FF00, 32'h0, 0);

        @(posedge clk); #1;
        do_mt(3'b100, 32'hAAAA_5555);
        do_mt(3'b101, 32'h0F0F_0F0F);
        do_mt(3'b110, 32'hDEAD_BEEF);
        do_mt(3'b111, 32'hDEAD_BEEF);

        do_op(3'b000, 32'd12345, 32'hFFFF_0000, 5);
        do_op(3'b011, 32'hCAFE_F00D, 32'd3, N + 1);

        bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'h7654_3210; bus.b = 32'h0000_1357;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        ref_hi = '0; ref_lo = '0;
        chk("abort_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        reset_n = 1'b1;
        for (int c = 0; c < N + 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {30'b0, bus.busy, bus.done}, 32'd0);
        end
        do_op(3'b001, 32'd6, 32'd7, 0);
        chk("post_abort_lo", bus.lo, 32'd42);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if (i % 4 == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, (i % 3 == 0) ? int'($urandom_range(1, N + 1)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
